// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared FSM state encoding and count-width helper for the BNN XNOR accumulator
package bnn_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// rtl/xnor_popcount.sv - combinational count of matching bit positions between one activation and weight beat
module xnor_popcount
    import bnn_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] w,
    output logic [CW-1:0]    cnt
);

    logic [WIDTH-1:0] match;

    assign match = ~(x ^ w);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_xnor_acc.sv
// rtl/bnn_xnor_acc.sv - streaming XNOR-popcount neuron with threshold output
// Optional out_cnt port (final accumulator value) enabled by BNN_XNOR_ACC_COUNT_EN.
module bnn_xnor_acc
    import bnn_pkg::*;
#(
    parameter int   WIDTH = 4,
    parameter int   BEATS = 4,
    localparam int  CW    = clog2(WIDTH * BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_w,
    input  logic             in_last,
    input  logic [CW-1:0]    thr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_o,
`ifdef BNN_XNOR_ACC_COUNT_EN
    output logic [CW-1:0]    out_cnt,
`endif
    output logic             out_err
);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] acc;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] thr_q;
    logic [CW-1:0] beat_pop;
    logic          err_q;
    logic          accept;
    logic          at_max;
    logic          final_beat;

    xnor_popcount #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_pop (
        .x   (in_x),
        .w   (in_w),
        .cnt (beat_pop)
    );

    assign at_max = (beat_cnt == CW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        final_beat = 1'b0;
        case (state)
            ACC: begin
                in_ready   = 1'b1;
                accept     = in_valid;
                final_beat = in_valid && (in_last || at_max);
                if (final_beat) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    // Error is a length mismatch: last flag and the beat limit disagree on the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
            thr_q    <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            acc      <= acc + beat_pop;
            beat_cnt <= beat_cnt + 1'b1;
            if (final_beat) begin
                thr_q <= thr;
                err_q <= in_last ^ at_max;
            end
        end else if (out_valid && out_ready) begin
            acc      <= '0;
            beat_cnt <= '0;
        end
    end

    assign out_o   = out_valid && (acc >= thr_q);
    assign out_err = out_valid && err_q;

`ifdef BNN_XNOR_ACC_COUNT_EN
    assign out_cnt = out_valid ? acc : '0;
`endif

endmodule

// File: tb/tb_bnn_xnor_acc.sv
// tb/tb_bnn_xnor_acc.sv - directed self-checking bench for bnn_xnor_acc (BEATS=2 and BEATS=4 instances)
module tb_bnn_xnor_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       a_in_valid, a_in_ready, a_in_last;
    logic [3:0] a_in_x, a_in_w, a_thr;
    logic       a_out_valid, a_out_ready, a_out_o, a_out_err;
    logic [3:0] a_out_cnt;

    logic       b_in_valid, b_in_ready, b_in_last;
    logic [3:0] b_in_x, b_in_w;
    logic [4:0] b_thr;
    logic       b_out_valid, b_out_ready, b_out_o, b_out_err;
    logic [4:0] b_out_cnt;

    int errors = 0;
    int checks = 0;

    logic [3:0] bx [6][4];
    logic [3:0] bw [6][4];
    int         bcnt [6];
    logic [4:0] bt [6];

    bnn_xnor_acc #(.WIDTH(4), .BEATS(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_x      (a_in_x),
        .in_w      (a_in_w),
        .in_last   (a_in_last),
        .thr       (a_thr),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_o     (a_out_o),
`ifdef BNN_XNOR_ACC_COUNT_EN
        .out_cnt   (a_out_cnt),
`endif
        .out_err   (a_out_err)
    );

    bnn_xnor_acc #(.WIDTH(4), .BEATS(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_x      (b_in_x),
        .in_w      (b_in_w),
        .in_last   (b_in_last),
        .thr       (b_thr),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_o     (b_out_o),
`ifdef BNN_XNOR_ACC_COUNT_EN
        .out_cnt   (b_out_cnt),
`endif
        .out_err   (b_out_err)
    );

`ifndef BNN_XNOR_ACC_COUNT_EN
    assign a_out_cnt = '0;
    assign b_out_cnt = '0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_beat(input logic [3:0] x, input logic [3:0] w, input logic last, input logic [3:0] t);
        a_in_valid = 1'b1;
        a_in_x     = x;
        a_in_w     = w;
        a_in_last  = last;
        a_thr      = t;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_x     = 4'h0;
        a_in_w     = 4'h0;
        a_in_last  = 1'b1;
        a_thr      = 4'h0;
    endtask

    task automatic a_expect(input string tag, input logic o, input logic err, input logic [3:0] cnt);
        check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
        check({tag, "_ready"}, 32'(a_in_ready), 32'd0);
        check({tag, "_o"}, 32'(a_out_o), 32'(o));
        check({tag, "_err"}, 32'(a_out_err), 32'(err));
`ifdef BNN_XNOR_ACC_COUNT_EN
        check({tag, "_cnt"}, 32'(a_out_cnt), 32'(cnt));
`endif
    endtask

    task automatic a_ack(input string tag);
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check({tag, "_ack_valid"}, 32'(a_out_valid), 32'd0);
        check({tag, "_ack_ready"}, 32'(a_in_ready), 32'd1);
    endtask

    task automatic b_frame(input int f, input bit gaps);
        int n;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                n = $urandom_range(0, 3);
                repeat (n) @(negedge clk);
            end
            b_in_valid = 1'b1;
            b_in_x     = bx[f][i];
            b_in_w     = bw[f][i];
            b_in_last  = (i == 3);
            b_thr      = (i == 3) ? bt[f] : 5'($urandom_range(0, 16));
            @(negedge clk);
            b_in_valid = 1'b0;
            b_in_x     = 4'($urandom);
            b_in_w     = 4'($urandom);
            b_in_last  = 1'b1;
            b_thr      = 5'($urandom_range(0, 16));
        end
        n = 0;
        while (!b_out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("r29_f%0d_g%0d_valid", f, gaps), 32'(b_out_valid), 32'd1);
        check($sformatf("r29_f%0d_g%0d_o", f, gaps), 32'(b_out_o), 32'(bcnt[f] >= int'(bt[f])));
        check($sformatf("r29_f%0d_g%0d_err", f, gaps), 32'(b_out_err), 32'd0);
`ifdef BNN_XNOR_ACC_COUNT_EN
        check($sformatf("r29_f%0d_g%0d_cnt", f, gaps), 32'(b_out_cnt), 32'(bcnt[f]));
`endif
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] m;

        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_x = 4'h0; a_in_w = 4'h0; a_in_last = 1'b0; a_thr = 4'h0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_x = 4'h0; b_in_w = 4'h0; b_in_last = 1'b0; b_thr = 5'h0;
        b_out_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_valid", 32'(a_out_valid), 32'd0);
        check("rst_ready", 32'(a_in_ready), 32'd1);
        check("rst_o", 32'(a_out_o), 32'd0);
        check("rst_err", 32'(a_out_err), 32'd0);
        check("rst_b_valid", 32'(b_out_valid), 32'd0);
`ifdef BNN_XNOR_ACC_COUNT_EN
        check("rst_cnt", 32'(a_out_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(a_in_ready), 32'd1);

        // All-match frame: 4+4 = 8, threshold 8.
        a_beat(4'h0, 4'h0, 1'b0, 4'd8);
        check("r24_mid_valid", 32'(a_out_valid), 32'd0);
        a_beat(4'h0, 4'h0, 1'b1, 4'd8);
        a_expect("r24", 1'b1, 1'b0, 4'd8);
        a_ack("r24");

        // 0011/0111 -> 3 matches, 0000/1101 -> 1 match, total 4.
        a_beat(4'h3, 4'h7, 1'b0, 4'd0);
        a_beat(4'h0, 4'hd, 1'b1, 4'd4);
        a_expect("r25_thr4", 1'b1, 1'b0, 4'd4);
        a_ack("r25_thr4");
        a_beat(4'h3, 4'h7, 1'b0, 4'd15);
        a_beat(4'h0, 4'hd, 1'b1, 4'd5);
        a_expect("r25_thr5", 1'b0, 1'b0, 4'd4);
        a_ack("r25_thr5");

        // Backpressure: result held, offered beats refused, including the handshake cycle.
        a_beat(4'h0, 4'h0, 1'b0, 4'd0);
        a_beat(4'h0, 4'h0, 1'b1, 4'd8);
        a_expect("r26_first", 1'b1, 1'b0, 4'd8);
        a_in_valid = 1'b1; a_in_x = 4'h0; a_in_w = 4'h0; a_in_last = 1'b1; a_thr = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_expect($sformatf("r26_hold%0d", k), 1'b1, 1'b0, 4'd8);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        check("r26_hs_valid", 32'(a_out_valid), 32'd0);
        check("r26_hs_ready", 32'(a_in_ready), 32'd1);
        a_beat(4'hf, 4'h0, 1'b0, 4'd0);
        a_beat(4'hf, 4'h0, 1'b1, 4'd1);
        a_expect("r26_clear", 1'b0, 1'b0, 4'd0);
        a_ack("r26_clear");

        // Early last on beat 1.
        a_beat(4'ha, 4'ha, 1'b1, 4'd4);
        a_expect("r27_early", 1'b1, 1'b1, 4'd4);
        a_ack("r27_early");
        // Missing last, forced end after beat 2.
        a_beat(4'hf, 4'hf, 1'b0, 4'd0);
        check("r27_forced_mid_valid", 32'(a_out_valid), 32'd0);
        a_beat(4'h0, 4'hf, 1'b0, 4'd5);
        a_expect("r27_forced", 1'b0, 1'b1, 4'd4);
        a_ack("r27_forced");

        // Reset mid-frame.
        a_beat(4'h0, 4'h0, 1'b0, 4'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("r28_rst_valid", 32'(a_out_valid), 32'd0);
        check("r28_rst_ready", 32'(a_in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        a_beat(4'hf, 4'hf, 1'b0, 4'd0);
        check("r28_mid_valid", 32'(a_out_valid), 32'd0);
        a_beat(4'hf, 4'hf, 1'b1, 4'd8);
        a_expect("r28_clean", 1'b1, 1'b0, 4'd8);

        // Reset while holding a result.
        rst_n = 1'b0;
        @(negedge clk);
        check("r28_out_rst_valid", 32'(a_out_valid), 32'd0);
        check("r28_out_rst_o", 32'(a_out_o), 32'd0);
        check("r28_out_rst_ready", 32'(a_in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        a_beat(4'h3, 4'h7, 1'b0, 4'd0);
        a_beat(4'h0, 4'hd, 1'b1, 4'd5);
        a_expect("r28_after", 1'b0, 1'b0, 4'd4);
        a_ack("r28_after");

        // BEATS=4 reference-model frames, thresholds placed around the true count.
        for (int f = 0; f < 6; f++) begin
            bcnt[f] = 0;
            for (int i = 0; i < 4; i++) begin
                bx[f][i] = 4'($urandom);
                bw[f][i] = 4'($urandom);
                m = ~(bx[f][i] ^ bw[f][i]);
                bcnt[f] = bcnt[f] + $countones(m);
            end
            case (f % 3)
                0:       bt[f] = 5'(bcnt[f]);
                1:       bt[f] = 5'(bcnt[f] + 1);
                default: bt[f] = (bcnt[f] == 0) ? 5'd0 : 5'(bcnt[f] - 1);
            endcase
        end
        for (int f = 0; f < 6; f++) b_frame(f, 1'b0);
        for (int f = 0; f < 6; f++) b_frame(f, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
